// File: rtl/spike_packet_encoder.sv
// Spike packet encoder: buffers spiking neuron IDs and emits spike/EOT packets over valid/ready.
// Optional build macro SPIKE_COUNT_EN adds per-timestep spike counters (spike_count, last_count).
module spike_packet_encoder #(
  parameter int NEURON_ID_W = 8,
  parameter int NODE_ID_W   = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NODE_ID_W-1:0]             node_id,
  input  logic                             spike_valid,
  input  logic                             spike_in,
  input  logic [NEURON_ID_W-1:0]           spike_neuron_id,
  input  logic                             timestep_end,
  input  logic                             clear_overflow,
  output logic [NODE_ID_W+NEURON_ID_W:0]   pkt_data,
  output logic                             pkt_valid,
  input  logic                             pkt_ready,
  output logic                             fifo_full,
  output logic                             overflow,
  output logic                             busy
`ifdef SPIKE_COUNT_EN
  ,
  output logic [NEURON_ID_W:0]             spike_count,
  output logic [NEURON_ID_W:0]             last_count
`endif
);
  localparam int PKT_W = 1 + NODE_ID_W + NEURON_ID_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                state;
  logic [FIFO_DEPTH-1:0][NEURON_ID_W-1:0] mem;
  logic [AW-1:0]                         wr_ptr, rd_ptr;
  logic [CW-1:0]                         count;
  logic                                  eot_pending;
  logic push, empty, full, load_slot, pop, wr_en, drop, load_eot;

  assign push      = spike_valid & spike_in;
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  // A new packet may be loaded when the link is idle or the current one is accepted now.
  assign load_slot = (state == IDLE) | ((state == SEND) & pkt_ready);
  assign pop       = load_slot & ~empty;
  assign load_eot  = load_slot & empty & eot_pending;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  assign fifo_full = full;
  assign busy      = ~empty | eot_pending | pkt_valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= spike_neuron_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      eot_pending <= 1'b0;
    end else begin
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      // A new timestep_end landing on the EOT load cycle opens a fresh pending EOT.
      if (timestep_end)  eot_pending <= 1'b1;
      else if (load_eot) eot_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            pkt_data  <= {1'b0, node_id, mem[rd_ptr]};
            pkt_valid <= 1'b1;
            state     <= SEND;
          end else if (load_eot) begin
            pkt_data  <= {1'b1, node_id, {NEURON_ID_W{1'b0}}};
            pkt_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (pop) begin
            pkt_data <= {1'b0, node_id, mem[rd_ptr]};
          end else if (load_eot) begin
            pkt_data <= {1'b1, node_id, {NEURON_ID_W{1'b0}}};
          end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          pkt_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [NEURON_ID_W:0] count_inc;
  assign count_inc = (&spike_count) ? spike_count : spike_count + 1'b1;

  // Dropped spikes count too; a push on the timestep_end cycle belongs to the ending step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_count <= '0;
      last_count  <= '0;
    end else if (timestep_end) begin
      last_count  <= push ? count_inc : spike_count;
      spike_count <= '0;
    end else if (push) begin
      spike_count <= count_inc;
    end
  end
`else
  // Counter build disabled: packet path is unchanged.
`endif

endmodule
